// File: rtl/convertidor_bin_bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM encoding,
// digit width and the double-dabble adjust constants.
package convertidor_bin_bcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int BCD_W      = 4;
  localparam int ADJ_THRESH = 5;
  localparam int ADJ_ADD    = 3;

endpackage

// File: rtl/convertidor_bin_bcd_ajuste_digito.sv
// Double-dabble digit adjust: a BCD digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module ajuste_digito
  import convertidor_bin_bcd_pkg::*;
(
  input  logic [BCD_W-1:0] digit_in,
  output logic [BCD_W-1:0] digit_out
);

  always_comb begin
    // NOTE: default assignment first, so no path leaves digit_out unassigned (no latch).
    digit_out = digit_in;
    if (digit_in >= BCD_W'(ADJ_THRESH))
      digit_out = digit_in + BCD_W'(ADJ_ADD);
  end

endmodule

// File: rtl/convertidor_bin_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle,
// with start/done handshake and optional two's-complement input.
module convertidor_bin_bcd
  import convertidor_bin_bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter int SIGNED = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WIDTH-1:0]          bin_in,
  output logic                      busy,
  output logic                      done,
  output logic [BCD_W*DIGITS-1:0]   bcd_out,
  output logic                      neg,
  output logic                      ovf
);

  localparam int CNT_W   = $clog2(WIDTH + 1);
  localparam int BCD_TOT = BCD_W * DIGITS;

  state_t               state;
  logic [BCD_TOT-1:0]   scratch;
  logic [BCD_TOT-1:0]   scratch_adj;
  logic [BCD_TOT-1:0]   scratch_next;
  logic [WIDTH-1:0]     mag;
  logic [WIDTH-1:0]     mag_load;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf_s;
  logic                 neg_s;
  logic                 ovf_next;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    ajuste_digito u_adj (
      .digit_in  (scratch[g*BCD_W +: BCD_W]),
      .digit_out (scratch_adj[g*BCD_W +: BCD_W])
    );
  end

  // The bit leaving the top digit means the value needs more than DIGITS digits.
  assign scratch_next = {scratch_adj[BCD_TOT-2:0], mag[WIDTH-1]};
  assign ovf_next     = ovf_s | scratch_adj[BCD_TOT-1];
  assign mag_load     = (SIGNED != 0 && bin_in[WIDTH-1]) ? -bin_in : bin_in;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state, so every register samples pre-edge values.
    if (rst) begin
      state   <= S_IDLE;
      scratch <= '0;
      mag     <= '0;
      cnt     <= '0;
      ovf_s   <= 1'b0;
      neg_s   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
      neg     <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state   <= S_SHIFT;
            busy    <= 1'b1;
            mag     <= mag_load;
            neg_s   <= (SIGNED != 0) && bin_in[WIDTH-1];
            scratch <= '0;
            ovf_s   <= 1'b0;
            cnt     <= CNT_W'(WIDTH);
          end else begin
            state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          scratch <= scratch_next;
          mag     <= mag << 1;
          ovf_s   <= ovf_next;
          cnt     <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state   <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            bcd_out <= scratch_next;
            ovf     <= ovf_next;
            neg     <= neg_s;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_convertidor_bin_bcd.sv
// Bench for convertidor_bin_bcd: three instances (unsigned/3 digits,
// signed/3 digits, unsigned/2 digits) driven by the same stimulus.
module tb_convertidor_bin_bcd;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  bin_in;

  logic        busy_u, done_u, neg_u, ovf_u;
  logic [11:0] bcd_u;
  logic        busy_s, done_s, neg_s, ovf_s;
  logic [11:0] bcd_s;
  logic        busy_2, done_2, neg_2, ovf_2;
  logic [7:0]  bcd_2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  convertidor_bin_bcd #(.WIDTH(8), .DIGITS(3), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy_u), .done(done_u), .bcd_out(bcd_u), .neg(neg_u), .ovf(ovf_u)
  );

  convertidor_bin_bcd #(.WIDTH(8), .DIGITS(3), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy_s), .done(done_s), .bcd_out(bcd_s), .neg(neg_s), .ovf(ovf_s)
  );

  convertidor_bin_bcd #(.WIDTH(8), .DIGITS(2), .SIGNED(0)) dut_2 (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy_2), .done(done_2), .bcd_out(bcd_2), .neg(neg_2), .ovf(ovf_2)
  );

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd_u;
    logic [11:0] bcd_s;
    logic        neg_s;
    logic [7:0]  bcd_2;
    logic        ovf_2;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present start for one cycle (called at a falling edge) and wait for done.
  // lat counts falling edges from the start request until done is seen.
  task automatic launch(input logic [7:0] v, output int lat, output int busy_n);
    start  = 1'b1;
    bin_in = v;
    lat    = 0;
    busy_n = 0;
    do begin
      @(negedge clk);
      start  = 1'b0;
      bin_in = 8'($urandom);
      lat++;
      if (busy_u) busy_n++;
    end while (!done_u && lat < 40);
  endtask

  task automatic check_all(input string tag, input vec_t e);
    check({tag, " done_u"}, done_u, 1'b1);
    check({tag, " done_s"}, done_s, 1'b1);
    check({tag, " done_2"}, done_2, 1'b1);
    check({tag, " bcd_u"},  bcd_u,  e.bcd_u);
    check({tag, " neg_u"},  neg_u,  1'b0);
    check({tag, " ovf_u"},  ovf_u,  1'b0);
    check({tag, " bcd_s"},  bcd_s,  e.bcd_s);
    check({tag, " neg_s"},  neg_s,  e.neg_s);
    check({tag, " ovf_s"},  ovf_s,  1'b0);
    check({tag, " bcd_2"},  bcd_2,  e.bcd_2);
    check({tag, " ovf_2"},  ovf_2,  e.ovf_2);
    check({tag, " neg_2"},  neg_2,  1'b0);
  endtask

  // Decimal reference: magnitude split by repeated division by ten.
  function automatic void model(input int v, input bit sgn, input int nd,
                                output logic [11:0] bcd, output logic n, output logic o);
    int m;
    int lim;
    m = v;
    n = 1'b0;
    if (sgn && v >= 128) begin
      m = 256 - v;
      n = 1'b1;
    end
    lim = (nd == 2) ? 100 : 1000;
    o   = (m >= lim);
    bcd = '0;
    for (int k = 0; k < nd; k++) begin
      bcd[4*k +: 4] = 4'(m % 10);
      m = m / 10;
    end
  endfunction

  function automatic bit digits_ok(input logic [11:0] b);
    for (int k = 0; k < 3; k++)
      if (b[4*k +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    int          lat;
    int          busy_n;
    int          n;
    bit          seen;
    logic [11:0] e_bcd;
    logic        e_neg;
    logic        e_ovf;

    vecs[0] = '{8'd0,   12'h000, 12'h000, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'd255, 12'h255, 12'h001, 1'b1, 8'h55, 1'b1};
    vecs[2] = '{8'd99,  12'h099, 12'h099, 1'b0, 8'h99, 1'b0};
    vecs[3] = '{8'h80,  12'h128, 12'h128, 1'b1, 8'h28, 1'b1};
    vecs[4] = '{8'hF6,  12'h246, 12'h010, 1'b1, 8'h46, 1'b1};
    vecs[5] = '{8'd200, 12'h200, 12'h056, 1'b1, 8'h00, 1'b1};
    vecs[6] = '{8'd57,  12'h057, 12'h057, 1'b0, 8'h57, 1'b0};
    vecs[7] = '{8'd127, 12'h127, 12'h127, 1'b0, 8'h27, 1'b1};
    vecs[8] = '{8'd100, 12'h100, 12'h100, 1'b0, 8'h00, 1'b1};
    vecs[9] = '{8'h81,  12'h129, 12'h127, 1'b1, 8'h29, 1'b1};

    rst    = 1'b1;
    start  = 1'b0;
    bin_in = 8'd0;
    repeat (3) @(negedge clk);
    check("reset busy",  busy_u, 1'b0);
    check("reset done",  done_u, 1'b0);
    check("reset bcd_u", bcd_u,  12'h000);
    check("reset neg_s", neg_s,  1'b0);
    check("reset ovf_2", ovf_2,  1'b0);
    check("reset bcd_2", bcd_2,  8'h00);
    rst = 1'b0;
    @(negedge clk);

    // Directed table: latency, busy length, results, single-cycle done.
    for (int i = 0; i < 10; i++) begin
      launch(vecs[i].bin, lat, busy_n);
      check($sformatf("vec%0d latency", i), lat, 9);
      check($sformatf("vec%0d busy cycles", i), busy_n, 8);
      check_all($sformatf("vec%0d", i), vecs[i]);
      @(negedge clk);
      check($sformatf("vec%0d done pulse", i), done_u, 1'b0);
    end

    // Back-to-back: start presented during DONE.
    launch(8'd99, lat, busy_n);
    check_all("b2b first", vecs[2]);
    launch(8'd255, lat, busy_n);
    check("b2b latency", lat, 9);
    check_all("b2b second", vecs[1]);
    @(negedge clk);
    check("b2b done pulse", done_u, 1'b0);

    // start pulsed 3 cycles into a conversion is ignored.
    start  = 1'b1;
    bin_in = 8'd57;
    @(negedge clk);
    start  = 1'b0;
    bin_in = 8'd0;
    repeat (2) @(negedge clk);
    start  = 1'b1;
    bin_in = 8'd200;
    @(negedge clk);
    start  = 1'b0;
    n = 4;
    while (!done_u && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ignore latency", n, 9);
    check_all("ignore", vecs[6]);
    @(negedge clk);
    check("ignore no requeue", busy_u, 1'b0);

    // Reset 4 cycles into a conversion, after a result with neg/ovf set.
    launch(8'd200, lat, busy_n);
    check_all("pre-reset", vecs[5]);
    @(negedge clk);
    start  = 1'b1;
    bin_in = 8'd99;
    @(negedge clk);
    start  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy",  busy_u, 1'b0);
    check("midrst done",  done_u, 1'b0);
    check("midrst bcd_u", bcd_u,  12'h000);
    check("midrst neg_s", neg_s,  1'b0);
    check("midrst ovf_2", ovf_2,  1'b0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done_u || done_s || done_2) seen = 1'b1;
    end
    check("midrst no done", seen, 1'b0);
    launch(8'd57, lat, busy_n);
    check("postrst latency", lat, 9);
    check_all("postrst", vecs[6]);
    @(negedge clk);

    // rst and start together: rst wins.
    rst    = 1'b1;
    start  = 1'b1;
    bin_in = 8'd99;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("rst+start busy",  busy_u, 1'b0);
    @(negedge clk);
    check("rst+start idle",  busy_u, 1'b0);

    // Full sweep against the decimal model.
    for (int v = 0; v < 256; v++) begin
      launch(8'(v), lat, busy_n);
      check($sformatf("sweep%0d latency", v), lat, 9);
      model(v, 1'b0, 3, e_bcd, e_neg, e_ovf);
      check($sformatf("sweep%0d bcd_u", v), bcd_u, e_bcd);
      check($sformatf("sweep%0d ovf_u", v), ovf_u, e_ovf);
      model(v, 1'b1, 3, e_bcd, e_neg, e_ovf);
      check($sformatf("sweep%0d bcd_s", v), bcd_s, e_bcd);
      check($sformatf("sweep%0d neg_s", v), neg_s, e_neg);
      model(v, 1'b0, 2, e_bcd, e_neg, e_ovf);
      check($sformatf("sweep%0d bcd_2", v), bcd_2, e_bcd[7:0]);
      check($sformatf("sweep%0d ovf_2", v), ovf_2, e_ovf);
      check($sformatf("sweep%0d digits", v),
            {digits_ok(bcd_u), digits_ok(bcd_s), digits_ok({4'h0, bcd_2})}, 3'b111);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
